// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Decode-to-execute stage of the integer core. Drives the register file read
// addresses straight from the decoded source indices, resolves RAW hazards by
// forwarding from EX, MEM and WB, stalls on load-use (or on an EX result that is
// not yet available), and captures resolved operands plus control into a
// one-entry ID/EX register with valid/ready handshakes on both sides.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   id_valid_i / id_ready_o        upstream handshake
//   id_rs1_i, id_rs2_i, id_rd_i    source / destination register indices
//   id_use_rs1_i, id_use_rs2_i     source is actually read
//   id_we_i, id_is_load_i          instruction writes rd / is a load
//   id_imm_i, id_pc_i              immediate and PC
//   raddr_a_o, raddr_b_o           register file read addresses
//   rdata_a_i, rdata_b_i           register file read data (combinational)
//   ex_fwd_valid_i, ex_fwd_data_i  EX result of the held instruction
//   mem_fwd_valid_i/_rd_i/_data_i  MEM-stage result
//   wb_we_i, wb_waddr_i, wb_wdata_i register file write port (being committed)
//   flush_i                        kill held and incoming instruction
//   ex_valid_o / ex_ready_i        downstream handshake
//   ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o, ex_rd_o,
//   ex_we_o, ex_is_load_o          registered operands and control
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic                  id_we_i,
  input  logic                  id_is_load_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [DATA_WIDTH-1:0] id_pc_i,

  output logic [ADDR_WIDTH-1:0] raddr_a_o,
  output logic [ADDR_WIDTH-1:0] raddr_b_o,
  input  logic [DATA_WIDTH-1:0] rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rdata_b_i,

  input  logic                  ex_fwd_valid_i,
  input  logic [DATA_WIDTH-1:0] ex_fwd_data_i,
  input  logic                  mem_fwd_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,

  input  logic                  flush_i,

  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [ADDR_WIDTH-1:0] ex_rd_o,
  output logic                  ex_we_o,
  output logic                  ex_is_load_o
);

  // ID/EX register
  logic                  ex_valid_reg;
  logic [DATA_WIDTH-1:0] ex_rs1_data_reg;
  logic [DATA_WIDTH-1:0] ex_rs2_data_reg;
  logic [DATA_WIDTH-1:0] ex_imm_reg;
  logic [DATA_WIDTH-1:0] ex_pc_reg;
  logic [ADDR_WIDTH-1:0] ex_rd_reg;
  logic                  ex_we_reg;
  logic                  ex_is_load_reg;

  // Per-source views: index 0 is rs1, index 1 is rs2
  logic [1:0][ADDR_WIDTH-1:0] src_idx;
  logic [1:0]                 src_use;
  logic [1:0][DATA_WIDTH-1:0] src_rdata;
  logic [1:0][DATA_WIDTH-1:0] operand_next;
  logic [1:0]                 src_hazard;

  logic hazard;
  logic advance;
  logic capture;

  assign raddr_a_o = id_rs1_i;
  assign raddr_b_o = id_rs2_i;

  assign src_idx[0]   = id_rs1_i;
  assign src_idx[1]   = id_rs2_i;
  assign src_use[0]   = id_use_rs1_i;
  assign src_use[1]   = id_use_rs2_i;
  assign src_rdata[0] = rdata_a_i;
  assign src_rdata[1] = rdata_b_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic live;
      logic ex_hit;
      logic mem_hit;
      logic wb_hit;

      // An unused source neither forwards nor stalls; it just passes RF data.
      assign live    = src_use[gi] && (src_idx[gi] != '0);
      assign ex_hit  = live && ex_valid_reg && ex_we_reg && (ex_rd_reg == src_idx[gi]);
      assign mem_hit = live && mem_fwd_valid_i && (mem_fwd_rd_i == src_idx[gi]);
      // WB bypass: the RF commits on the same edge we capture, so its read
      // data is still stale this cycle.
      assign wb_hit  = live && wb_we_i && (wb_waddr_i == src_idx[gi]);

      // Youngest producer wins: EX, then MEM, then WB, then the RF.
      assign operand_next[gi] = (src_idx[gi] == '0) ? '0             :
                                ex_hit              ? ex_fwd_data_i  :
                                mem_hit             ? mem_fwd_data_i :
                                wb_hit              ? wb_wdata_i     :
                                                      src_rdata[gi];

      // A load's data is never available from EX; other producers stall
      // only until their result is flagged valid.
      assign src_hazard[gi] = ex_hit && (ex_is_load_reg || !ex_fwd_valid_i);
    end
  endgenerate

  assign hazard     = |src_hazard;
  assign advance    = !ex_valid_reg || ex_ready_i;
  assign id_ready_o = flush_i || (advance && !hazard);
  assign capture    = id_valid_i && id_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg    <= 1'b0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      ex_imm_reg      <= '0;
      ex_pc_reg       <= '0;
      ex_rd_reg       <= '0;
      ex_we_reg       <= 1'b0;
      ex_is_load_reg  <= 1'b0;
    end else if (flush_i) begin
      // id_ready_o is forced high so upstream drops its instruction too.
      ex_valid_reg <= 1'b0;
    end else if (capture) begin
      ex_valid_reg    <= 1'b1;
      ex_rs1_data_reg <= operand_next[0];
      ex_rs2_data_reg <= operand_next[1];
      ex_imm_reg      <= id_imm_i;
      ex_pc_reg       <= id_pc_i;
      ex_rd_reg       <= id_rd_i;
      ex_we_reg       <= id_we_i;
      ex_is_load_reg  <= id_is_load_i;
    end else if (advance) begin
      // Bubble (including the load-use bubble); data fields are don't-care.
      ex_valid_reg <= 1'b0;
    end
  end

  assign ex_valid_o    = ex_valid_reg;
  assign ex_rs1_data_o = ex_rs1_data_reg;
  assign ex_rs2_data_o = ex_rs2_data_reg;
  assign ex_imm_o      = ex_imm_reg;
  assign ex_pc_o       = ex_pc_reg;
  assign ex_rd_o       = ex_rd_reg;
  assign ex_we_o       = ex_we_reg;
  assign ex_is_load_o  = ex_is_load_reg;

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute pipeline stage of the integer core. It drives the register file read ports from the decoded source indices and resolves RAW hazards by forwarding from EX, MEM and WB. It stalls one cycle on load-use and captures resolved operands plus control into a one-entry ID/EX register with valid/ready handshakes on both sides.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid_i / id_ready_o  in/out  1  upstream handshake
- id_rs1_i, id_rs2_i, id_rd_i  in  ADDR_WIDTH  source/destination indices
- id_use_rs1_i, id_use_rs2_i  in  1  source actually read
- id_we_i, id_is_load_i  in  1  writes rd / is a load
- id_imm_i, id_pc_i  in  DATA_WIDTH  immediate, PC
- raddr_a_o, raddr_b_o  out  ADDR_WIDTH  register file read addresses
- rdata_a_i, rdata_b_i  in  DATA_WIDTH  register file read data (combinational)
- ex_fwd_valid_i  in  1  EX result for the held instruction is available this cycle
- ex_fwd_data_i  in  DATA_WIDTH  that result
- mem_fwd_valid_i, mem_fwd_rd_i, mem_fwd_data_i  in  1/ADDR_WIDTH/DATA_WIDTH  MEM-stage result
- wb_we_i, wb_waddr_i, wb_wdata_i  in  1/ADDR_WIDTH/DATA_WIDTH  same signals as the register file write port
- flush_i  in  1  kill held and incoming instruction
- ex_valid_o / ex_ready_i  out/in  1  downstream handshake
- ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  out  DATA_WIDTH  registered operands
- ex_rd_o  out  ADDR_WIDTH;  ex_we_o, ex_is_load_o  out  1  registered control

## Operation
- raddr_a_o = id_rs1_i, raddr_b_o = id_rs2_i, combinational, always driven.
- Per source s in {rs1, rs2}, operand priority (first match wins):
  - index 0 -> 0.
  - EX: ex_valid_o && ex_we_o && ex_rd_o == s -> ex_fwd_data_i.
  - MEM: mem_fwd_valid_i && mem_fwd_rd_i == s -> mem_fwd_data_i.
  - WB: wb_we_i && wb_waddr_i == s -> wb_wdata_i. Needed because the register file commits at the edge.
  - else register file data.
- hazard is high when a used source s != 0 matches ex_rd_o with ex_valid_o && ex_we_o, and (ex_is_load_o || !ex_fwd_valid_i). Unused sources never cause hazard or forwarding.
- advance = !ex_valid_o || ex_ready_i.
- id_ready_o = flush_i || (advance && !hazard).
- Register update, with priority:
  1. flush_i: ex_valid_o <= 0; incoming instruction is discarded.
  2. id_valid_i && id_ready_o: capture resolved operands and id_* control; ex_valid_o <= 1.
  3. advance: ex_valid_o <= 0. This covers a bubble, including the load-use bubble.
  4. else: hold all outputs unchanged.
- No combinational path from ex_ready_i to ex_* data outputs.

## Timing
- Reset (async assert, sync to clk on release): ex_valid_o = 0 and all ex_* data/control outputs = 0. id_ready_o then equals !hazard = 1.
- Latency: accepted in cycle N, presented on ex_* in cycle N+1. Throughput is 1/cycle with no hazards.
- Load-use: exactly one bubble. The dependent instruction is accepted the cycle after the load leaves and takes the MEM forward.
- EX producer not ready (ex_fwd_valid_i = 0): stall until it asserts.
- Backpressure: while ex_valid_o && !ex_ready_i, the outputs hold stable and id_ready_o = 0.
- Simultaneous EX/MEM/WB match on the same index: EX wins.
- Reset mid-stall drops the held instruction. Flush in the same cycle as ex_ready_i still clears.

## Test plan
- Independent stream: three instructions, id_valid_i held high, ex_ready_i = 1, register file returns x5 = 0x11 -> ex_valid_o high on cycles 1..3, and the operands match the register file.
- EX forward: an instruction held with rd = 3, ex_fwd_valid_i = 1 and ex_fwd_data_i = 0xAAAA_0001, followed by an incoming instruction with rs1 = 3 -> accepted with no stall, and ex_rs1_data_o = 0xAAAA_0001.
- Load-use: a held load with rd = 7, followed by an incoming instruction with rs2 = 7. Expect id_ready_o = 0 for one cycle and ex_valid_o = 0 for one bubble. Next cycle, with mem_fwd_rd_i = 7 and mem_fwd_data_i = 0x55 -> ex_rs2_data_o = 0x55.
- Priority and x0: EX, MEM and WB all target rd = 4 (0x1/0x2/0x3), and rs1 = 4 -> 0x1. With rs1 = 0 and wb_waddr_i = 0 -> 0.
- Backpressure then flush: hold ex_ready_i = 0 for 3 cycles -> outputs stable and id_ready_o = 0. Then assert flush_i -> next cycle ex_valid_o = 0, and the incoming instruction is not captured.
- Async reset asserted mid-stall, between clock edges -> ex_valid_o drops immediately, and all outputs read 0.
